// File: rtl/multi_updown_counter.sv
// -----------------------------------------------------------------------------
// multi_updown_counter
//
// A bank of N independent W-bit up/down counters. Each channel has
// increment/decrement requests, a synchronous clear and a synchronous load.
// Each channel also has sticky overflow and underflow flags. Arithmetic
// either wraps (SAT=0) or saturates at 0 and 2^W-1 (SAT=1). The flags are
// set whenever a channel crosses a boundary, in both modes.
//
// Per-channel priority at each posedge, highest first:
//   clr > load > (inc & dec: hold) > inc > dec > hold
//
// Optional feature: define MULTI_UPDOWN_COUNTER_SNAPSHOT_EN to add a snapshot
// register. When snap=1 at a posedge, it captures the pre-update value of
// every counter at once.
//
// Parameters:
//   N      number of channels (>= 1)
//   W      counter width per channel (>= 2)
//   SAT    0 = wrap-around, 1 = saturate
//   RSTVAL reset / clear value for every counter
//
// Ports:
//   clk       clock, all state updates on posedge
//   rst       asynchronous active-high reset
//   inc       per-channel increment request
//   dec       per-channel decrement request
//   clr       per-channel synchronous clear to RSTVAL (also clears flags)
//   load      per-channel synchronous load
//   load_val  load data, channel i = bits [i*W +: W]
//   flag_clr  synchronous clear of all ovf/unf flags
//   cnt       counter values, channel i = bits [i*W +: W]
//   ovf       sticky overflow flag per channel
//   unf       sticky underflow flag per channel
//   zero      combinational, channel count == 0
//   snap      (snapshot build only) capture request
//   snap_cnt  (snapshot build only) captured counter values
// -----------------------------------------------------------------------------
module multi_updown_counter #(
   parameter int unsigned    N      = 4,
   parameter int unsigned    W      = 4,
   parameter bit             SAT    = 1'b0,
   parameter logic [W-1:0]   RSTVAL = '0
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [N-1:0]     inc,
   input  logic [N-1:0]     dec,
   input  logic [N-1:0]     clr,
   input  logic [N-1:0]     load,
   input  logic [N*W-1:0]   load_val,
   input  logic             flag_clr,
   output logic [N*W-1:0]   cnt,
   output logic [N-1:0]     ovf,
   output logic [N-1:0]     unf,
   output logic [N-1:0]     zero
`ifdef MULTI_UPDOWN_COUNTER_SNAPSHOT_EN
   ,
   input  logic             snap,
   output logic [N*W-1:0]   snap_cnt
`endif
);

   localparam logic [W-1:0] ONE = W'(1);

   logic [W-1:0] cnt_q [N];
   logic [W-1:0] cnt_d [N];
   logic [N-1:0] ovf_q, ovf_d;
   logic [N-1:0] unf_q, unf_d;

   // Next-state computation for every channel.
   always_comb begin
      // NOTE: every variable gets a default before any branch; otherwise
      // paths that skip an assignment would infer latches.
      cnt_d = cnt_q;
      // flag_clr applies to all channels, but a set condition on the same
      // edge still wins because the set below overrides this value.
      ovf_d = flag_clr ? '0 : ovf_q;
      unf_d = flag_clr ? '0 : unf_q;
      for (int i = 0; i < int'(N); i++) begin
         if (clr[i]) begin
            cnt_d[i] = RSTVAL;
            ovf_d[i] = 1'b0;
            unf_d[i] = 1'b0;
         end else if (load[i]) begin
            cnt_d[i] = load_val[i*W +: W];
         end else if (inc[i] && dec[i]) begin
            cnt_d[i] = cnt_q[i];
         end else if (inc[i]) begin
            if (cnt_q[i] == '1) begin
               ovf_d[i] = 1'b1;
               cnt_d[i] = SAT ? cnt_q[i] : '0;
            end else begin
               cnt_d[i] = cnt_q[i] + ONE;
            end
         end else if (dec[i]) begin
            if (cnt_q[i] == '0) begin
               unf_d[i] = 1'b1;
               cnt_d[i] = SAT ? cnt_q[i] : '1;
            end else begin
               cnt_d[i] = cnt_q[i] - ONE;
            end
         end
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         cnt_q <= '{default: RSTVAL};
         ovf_q <= '0;
         unf_q <= '0;
      end else begin
         // NOTE: sequential state uses non-blocking assignments so that all
         // registers update together from values sampled before the edge.
         cnt_q <= cnt_d;
         ovf_q <= ovf_d;
         unf_q <= unf_d;
      end
   end

   always_comb begin
      cnt  = '0;
      zero = '0;
      for (int i = 0; i < int'(N); i++) begin
         cnt[i*W +: W] = cnt_q[i];
         zero[i]       = (cnt_q[i] == '0);
      end
   end

   assign ovf = ovf_q;
   assign unf = unf_q;

`ifdef MULTI_UPDOWN_COUNTER_SNAPSHOT_EN
   // Captures the pre-update values. cnt reflects cnt_q before this edge.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         snap_cnt <= {N{RSTVAL}};
      end else if (snap) begin
         snap_cnt <= cnt;
      end
   end
`endif

endmodule

// File: tb/tb_multi_updown_counter.sv
// -----------------------------------------------------------------------------
// tb_multi_updown_counter
//
// Self-checking bench for multi_updown_counter with N=2, W=4 and RSTVAL=0.
// Two instances share the same stimulus. One uses wrap-around arithmetic and
// the other saturates. A behavioural model predicts each cycle's result.
// The prediction is pushed to a queue when the stimulus is driven. It is
// popped and compared after the DUT has taken the edge.
// -----------------------------------------------------------------------------
module tb_multi_updown_counter;

   localparam int N = 2;
   localparam int W = 4;

   typedef struct {
      logic [7:0] cnt_w;
      logic [7:0] cnt_s;
      logic [1:0] ovf_w;
      logic [1:0] unf_w;
      logic [1:0] ovf_s;
      logic [1:0] unf_s;
      logic [1:0] zero_w;
      logic [1:0] zero_s;
      logic [7:0] snap_w;
      logic [7:0] snap_s;
   } exp_t;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic [1:0] inc = '0, dec = '0, clr = '0, load = '0;
   logic [7:0] load_val = '0;
   logic       flag_clr = 1'b0;
   logic       snap = 1'b0;

   logic [7:0] cnt_w, cnt_s, snap_cnt_w, snap_cnt_s;
   logic [1:0] ovf_w, unf_w, zero_w, ovf_s, unf_s, zero_s;

   int checks = 0;
   int errors = 0;

   // model state, index 0 = wrap instance, 1 = saturate instance
   logic [3:0] m_cnt [2][2];
   logic [1:0] m_ovf [2];
   logic [1:0] m_unf [2];
   logic [7:0] m_snap [2];
   exp_t       sb_q [$];

   always #5 clk = ~clk;

   multi_updown_counter #(.N(N), .W(W), .SAT(1'b0), .RSTVAL(4'd0)) u_wrap (
      .clk(clk), .rst(rst), .inc(inc), .dec(dec), .clr(clr), .load(load),
      .load_val(load_val), .flag_clr(flag_clr),
      .cnt(cnt_w), .ovf(ovf_w), .unf(unf_w), .zero(zero_w)
`ifdef MULTI_UPDOWN_COUNTER_SNAPSHOT_EN
      , .snap(snap), .snap_cnt(snap_cnt_w)
`endif
   );

   multi_updown_counter #(.N(N), .W(W), .SAT(1'b1), .RSTVAL(4'd0)) u_sat (
      .clk(clk), .rst(rst), .inc(inc), .dec(dec), .clr(clr), .load(load),
      .load_val(load_val), .flag_clr(flag_clr),
      .cnt(cnt_s), .ovf(ovf_s), .unf(unf_s), .zero(zero_s)
`ifdef MULTI_UPDOWN_COUNTER_SNAPSHOT_EN
      , .snap(snap), .snap_cnt(snap_cnt_s)
`endif
   );

`ifndef MULTI_UPDOWN_COUNTER_SNAPSHOT_EN
   assign snap_cnt_w = '0;
   assign snap_cnt_s = '0;
`endif

   task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got=0x%0h expected=0x%0h at %0t", tag, got, exp, $time);
      end
   endtask

   function automatic logic [7:0] m_cnt_vec(input int s);
      return {m_cnt[s][1], m_cnt[s][0]};
   endfunction

   function automatic logic [1:0] m_zero_vec(input int s);
      return {m_cnt[s][1] == 4'd0, m_cnt[s][0] == 4'd0};
   endfunction

   task automatic model_reset();
      for (int s = 0; s < 2; s++) begin
         m_cnt[s][0] = 4'd0;
         m_cnt[s][1] = 4'd0;
         m_ovf[s]    = 2'b00;
         m_unf[s]    = 2'b00;
         m_snap[s]   = 8'h00;
      end
   endtask

   // Advances the model by one clock using the currently driven inputs.
   task automatic model_step();
      for (int s = 0; s < 2; s++) begin
         if (snap) m_snap[s] = m_cnt_vec(s);
         for (int i = 0; i < 2; i++) begin
            logic [3:0] c;
            logic       o, u;
            c = m_cnt[s][i];
            o = m_ovf[s][i] & ~flag_clr;
            u = m_unf[s][i] & ~flag_clr;
            if (clr[i]) begin
               c = 4'd0; o = 1'b0; u = 1'b0;
            end else if (load[i]) begin
               c = load_val[i*4 +: 4];
            end else if (inc[i] && !dec[i]) begin
               if (c == 4'd15) begin
                  o = 1'b1;
                  if (s == 0) c = 4'd0;
               end else c = c + 4'd1;
            end else if (dec[i] && !inc[i]) begin
               if (c == 4'd0) begin
                  u = 1'b1;
                  if (s == 0) c = 4'd15;
               end else c = c - 4'd1;
            end
            m_cnt[s][i] = c;
            m_ovf[s][i] = o;
            m_unf[s][i] = u;
         end
      end
   endtask

   function automatic exp_t model_expect();
      exp_t e;
      e.cnt_w  = m_cnt_vec(0);  e.cnt_s  = m_cnt_vec(1);
      e.ovf_w  = m_ovf[0];      e.ovf_s  = m_ovf[1];
      e.unf_w  = m_unf[0];      e.unf_s  = m_unf[1];
      e.zero_w = m_zero_vec(0); e.zero_s = m_zero_vec(1);
      e.snap_w = m_snap[0];     e.snap_s = m_snap[1];
      return e;
   endfunction

   task automatic compare(input string tag);
      exp_t e;
      if (sb_q.size() == 0) begin
         check({tag, "_queue_empty"}, 16'd0, 16'd1);
         return;
      end
      e = sb_q.pop_front();
      check({tag, "_cnt_w"},  16'(cnt_w),  16'(e.cnt_w));
      check({tag, "_cnt_s"},  16'(cnt_s),  16'(e.cnt_s));
      check({tag, "_ovf_w"},  16'(ovf_w),  16'(e.ovf_w));
      check({tag, "_unf_w"},  16'(unf_w),  16'(e.unf_w));
      check({tag, "_ovf_s"},  16'(ovf_s),  16'(e.ovf_s));
      check({tag, "_unf_s"},  16'(unf_s),  16'(e.unf_s));
      check({tag, "_zero_w"}, 16'(zero_w), 16'(e.zero_w));
      check({tag, "_zero_s"}, 16'(zero_s), 16'(e.zero_s));
`ifdef MULTI_UPDOWN_COUNTER_SNAPSHOT_EN
      check({tag, "_snap_w"}, 16'(snap_cnt_w), 16'(e.snap_w));
      check({tag, "_snap_s"}, 16'(snap_cnt_s), 16'(e.snap_s));
`endif
   endtask

   // Drives one cycle of stimulus at the negedge and queues the prediction.
   // After the posedge it compares the outputs, then returns the inputs to idle.
   task automatic step(input string tag,
                       input logic [1:0] i_inc, input logic [1:0] i_dec,
                       input logic [1:0] i_clr, input logic [1:0] i_load,
                       input logic [7:0] i_lv,  input logic i_fc,
                       input logic i_snap = 1'b0);
      @(negedge clk);
      inc = i_inc; dec = i_dec; clr = i_clr; load = i_load;
      load_val = i_lv; flag_clr = i_fc; snap = i_snap;
      model_step();
      sb_q.push_back(model_expect());
      @(posedge clk);
      #1;
      compare(tag);
      inc = '0; dec = '0; clr = '0; load = '0; load_val = '0;
      flag_clr = 1'b0; snap = 1'b0;
   endtask

   task automatic check_reset_state(input string tag);
      check({tag, "_cnt_w"},  16'(cnt_w),  16'h00);
      check({tag, "_cnt_s"},  16'(cnt_s),  16'h00);
      check({tag, "_ovf"},    16'({ovf_w, ovf_s}), 16'h0);
      check({tag, "_unf"},    16'({unf_w, unf_s}), 16'h0);
      check({tag, "_zero_w"}, 16'(zero_w), 16'h3);
      check({tag, "_zero_s"}, 16'(zero_s), 16'h3);
`ifdef MULTI_UPDOWN_COUNTER_SNAPSHOT_EN
      check({tag, "_snap"},   16'({snap_cnt_w, snap_cnt_s}), 16'h0);
`endif
   endtask

   initial begin
      model_reset();
      #1;
      check_reset_state("por");
      repeat (2) @(posedge clk);
      @(negedge clk);
      rst = 1'b0;

      // async reset between edges while channel 0 holds 7
      step("load7", 2'b01, 2'b00, 2'b00, 2'b01, 8'h07, 1'b0);
      #2;
      rst = 1'b1;
      #1;
      check_reset_state("async_rst");
      model_reset();
      @(negedge clk);
      rst = 1'b0;

      // wrap and saturate at the top of channel 0, then back down
      step("ld15_c0",  2'b00, 2'b00, 2'b00, 2'b01, 8'h0F, 1'b0);
      step("inc_top",  2'b01, 2'b00, 2'b00, 2'b00, 8'h00, 1'b0);
      step("dec_bot",  2'b00, 2'b01, 2'b00, 2'b00, 8'h00, 1'b0);

      // channel 1 held at the top for three increments
      step("ld15_c1",  2'b00, 2'b00, 2'b00, 2'b10, 8'hF0, 1'b0);
      for (int k = 0; k < 3; k++)
         step($sformatf("inc_c1_%0d", k), 2'b10, 2'b00, 2'b00, 2'b00, 8'h00, 1'b0);
      step("ld0_c1",   2'b00, 2'b00, 2'b00, 2'b10, 8'h00, 1'b0);
      step("dec_c1_0", 2'b00, 2'b10, 2'b00, 2'b00, 8'h00, 1'b0);

      // priority resolution on channel 0
      step("ld5",      2'b00, 2'b00, 2'b00, 2'b01, 8'h05, 1'b0);
      step("clr_ld",   2'b01, 2'b00, 2'b01, 2'b01, 8'h09, 1'b0);
      step("ld_inc",   2'b01, 2'b00, 2'b00, 2'b01, 8'h09, 1'b0);
      step("inc_dec",  2'b01, 2'b01, 2'b00, 2'b00, 8'h00, 1'b0);

      // flag_clr versus a new overflow on the same edge, then alone
      step("ld15_f",   2'b00, 2'b00, 2'b00, 2'b01, 8'h0F, 1'b0);
      step("fc_inc",   2'b01, 2'b00, 2'b00, 2'b00, 8'h00, 1'b1);
      step("fc_only",  2'b00, 2'b00, 2'b00, 2'b00, 8'h00, 1'b1);
      // set flags on both channels, then clear only channel 1
      step("ld_both0", 2'b00, 2'b00, 2'b00, 2'b11, 8'h00, 1'b0);
      step("dec_both", 2'b00, 2'b11, 2'b00, 2'b00, 8'h00, 1'b0);
      step("clr_c1",   2'b00, 2'b00, 2'b10, 2'b00, 8'h00, 1'b0);

      // snapshot captures the pre-update counts
      step("ld_3_12",  2'b00, 2'b00, 2'b00, 2'b11, 8'hC3, 1'b0);
      step("snap_inc", 2'b01, 2'b00, 2'b00, 2'b00, 8'h00, 1'b0, 1'b1);

      // random traffic; clr and flag_clr are kept rare so that flags accumulate
      for (int k = 0; k < 60; k++) begin
         logic [1:0] r_clr;
         logic       r_fc;
         r_clr = ($urandom_range(0, 7) == 0) ? 2'($urandom) : 2'b00;
         r_fc  = ($urandom_range(0, 9) == 0);
         step($sformatf("rnd_%0d", k), 2'($urandom), 2'($urandom), r_clr,
              ($urandom_range(0, 3) == 0) ? 2'($urandom) : 2'b00,
              8'($urandom), r_fc, 1'($urandom));
      end

      check("sb_drained", 16'(sb_q.size()), 16'd0);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

   // Safety net so the run always terminates.
   initial begin
      #50000;
      $display("FAIL timeout: simulation exceeded time limit");
      $fatal(1, "timeout");
   end

endmodule
